// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and timeout sizing for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_W_UP = 8'h57;
  localparam logic [7:0] ASCII_W_LO = 8'h77;
  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_TERM,
    ST_FLUSH
  } state_t;

  // Silent cycles allowed between bytes; zero means the timeout is disabled.
  function automatic int timeout_cycles(input int clk_freq, input int timeout_ms);
    return (clk_freq / 1000) * timeout_ms;
  endfunction

  function automatic int timeout_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f to a 4-bit nibble.
module hex_nibble_decode (
  input  logic [7:0] rx_byte,
  output logic [3:0] nibble,
  output logic       is_hex
);

  always_comb begin
    nibble = 4'h0;
    is_hex = 1'b0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      nibble = rx_byte[3:0];
      is_hex = 1'b1;
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      nibble = rx_byte[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII hex command parser: W<aa><dd><T> writes, R<aa><T> reads, with error
// reporting, resync on the next terminator and an inter-byte timeout.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int TIMEOUT_MS = 100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_wr_en,
  output logic       o_rd_en,
  output logic [7:0] o_addr,
  output logic [7:0] o_wr_data,
  output logic       o_err
);

  localparam int  TO_CYCLES = timeout_cycles(CLK_FREQ, TIMEOUT_MS);
  localparam int  TO_W      = timeout_width(TO_CYCLES);
  localparam bit  TO_EN     = (TO_CYCLES > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  state_t          state;
  logic            is_write;
  logic [7:0]      addr_sh;
  logic [7:0]      data_sh;
  logic [TO_W-1:0] to_cnt;

  logic [3:0] nibble;
  logic       is_hex;
  logic       is_term;
  logic       is_w;
  logic       is_r;

  hex_nibble_decode u_hex (
    .rx_byte (i_rx_data),
    .nibble  (nibble),
    .is_hex  (is_hex)
  );

  assign is_term = (i_rx_data == ASCII_CR) || (i_rx_data == ASCII_LF);
  assign is_w    = (i_rx_data == ASCII_W_UP) || (i_rx_data == ASCII_W_LO);
  assign is_r    = (i_rx_data == ASCII_R_UP) || (i_rx_data == ASCII_R_LO);

  // A received byte always takes priority over a timeout landing in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      is_write  <= 1'b0;
      addr_sh   <= 8'h00;
      data_sh   <= 8'h00;
      to_cnt    <= '0;
      o_wr_en   <= 1'b0;
      o_rd_en   <= 1'b0;
      o_err     <= 1'b0;
      o_addr    <= 8'h00;
      o_wr_data <= 8'h00;
    end else begin
      o_wr_en <= 1'b0;
      o_rd_en <= 1'b0;
      o_err   <= 1'b0;
      if (i_rx_valid) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (is_w) begin
              is_write <= 1'b1;
              state    <= ST_ADDR_HI;
            end else if (is_r) begin
              is_write <= 1'b0;
              state    <= ST_ADDR_HI;
            end else if (!is_term) begin
              o_err <= 1'b1;
              state <= ST_FLUSH;
            end
          end
          ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI, ST_DATA_LO: begin
            if (is_hex) begin
              if (state == ST_ADDR_HI || state == ST_ADDR_LO)
                addr_sh <= {addr_sh[3:0], nibble};
              else
                data_sh <= {data_sh[3:0], nibble};
              case (state)
                ST_ADDR_HI: state <= ST_ADDR_LO;
                ST_ADDR_LO: state <= is_write ? ST_DATA_HI : ST_TERM;
                ST_DATA_HI: state <= ST_DATA_LO;
                default:    state <= ST_TERM;
              endcase
            end else begin
              o_err <= 1'b1;
              state <= is_term ? ST_IDLE : ST_FLUSH;
            end
          end
          ST_TERM: begin
            if (is_term) begin
              o_addr <= addr_sh;
              if (is_write) begin
                o_wr_data <= data_sh;
                o_wr_en   <= 1'b1;
              end else begin
                o_rd_en <= 1'b1;
              end
              state <= ST_IDLE;
            end else begin
              o_err <= 1'b1;
              state <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            if (is_term)
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state == ST_IDLE) begin
        to_cnt <= '0;
      end else if (TO_EN) begin
        if (to_cnt == TO_LAST) begin
          to_cnt <= '0;
          state  <= ST_IDLE;
          if (state != ST_FLUSH)
            o_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser with a 20-cycle timeout.
module tb_uart_cmd_parser;

  localparam int CLK_FREQ   = 10_000;
  localparam int TIMEOUT_MS = 2;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       o_wr_en;
  logic       o_rd_en;
  logic [7:0] o_addr;
  logic [7:0] o_wr_data;
  logic       o_err;

  int compared   = 0;
  int mismatched = 0;
  int wr_cnt     = 0;
  int rd_cnt     = 0;
  int err_cnt    = 0;
  int overlap_cnt = 0;

  uart_cmd_parser #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_wr_en    (o_wr_en),
    .o_rd_en    (o_rd_en),
    .o_addr     (o_addr),
    .o_wr_data  (o_wr_data),
    .o_err      (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Strobe accounting, sampled away from the active edge.
  always @(negedge i_clk) begin
    if (o_wr_en) wr_cnt++;
    if (o_rd_en) rd_cnt++;
    if (o_err) err_cnt++;
    if ((32'(o_wr_en) + 32'(o_rd_en) + 32'(o_err)) > 1) overlap_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i]);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  task automatic clearCounts();
    wr_cnt  = 0;
    rd_cnt  = 0;
    err_cnt = 0;
  endtask

  initial begin
    i_rst      = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    idleCycles(3);
    i_rst = 1'b0;
    idleCycles(1);
    checkOutput("reset_wr_en", 32'(o_wr_en), 0);
    checkOutput("reset_rd_en", 32'(o_rd_en), 0);
    checkOutput("reset_err", 32'(o_err), 0);
    checkOutput("reset_addr", 32'(o_addr), 0);
    checkOutput("reset_wr_data", 32'(o_wr_data), 0);

    $display("[TB] write W3A5F<CR>");
    clearCounts();
    applyStimulus("W3A5F");
    sendByte(8'h0D);
    checkOutput("w1_wr_en", 32'(o_wr_en), 1);
    checkOutput("w1_addr", 32'(o_addr), 32'h3A);
    checkOutput("w1_data", 32'(o_wr_data), 32'h5F);
    idleCycles(3);
    checkOutput("w1_wr_cnt", wr_cnt, 1);
    checkOutput("w1_err_cnt", err_cnt, 0);

    $display("[TB] read r7e<LF> then blank CRLF");
    clearCounts();
    applyStimulus("r7e");
    sendByte(8'h0A);
    checkOutput("r1_rd_en", 32'(o_rd_en), 1);
    checkOutput("r1_addr", 32'(o_addr), 32'h7E);
    checkOutput("r1_data_kept", 32'(o_wr_data), 32'h5F);
    sendByte(8'h0D);
    sendByte(8'h0A);
    idleCycles(3);
    checkOutput("r1_rd_cnt", rd_cnt, 1);
    checkOutput("r1_wr_cnt", wr_cnt, 0);
    checkOutput("r1_err_cnt", err_cnt, 0);

    $display("[TB] bad hex W1G23<CR> then R01<CR>");
    clearCounts();
    applyStimulus("W1G");
    checkOutput("badhex_err", 32'(o_err), 1);
    applyStimulus("23");
    sendByte(8'h0D);
    applyStimulus("R01");
    sendByte(8'h0D);
    checkOutput("badhex_rd_en", 32'(o_rd_en), 1);
    checkOutput("badhex_addr", 32'(o_addr), 32'h01);
    idleCycles(3);
    checkOutput("badhex_err_cnt", err_cnt, 1);
    checkOutput("badhex_rd_cnt", rd_cnt, 1);
    checkOutput("badhex_wr_cnt", wr_cnt, 0);

    $display("[TB] early terminator W12<CR> then R05<CR>");
    clearCounts();
    applyStimulus("W12");
    sendByte(8'h0D);
    checkOutput("early_err", 32'(o_err), 1);
    applyStimulus("R05");
    sendByte(8'h0D);
    checkOutput("early_rd_en", 32'(o_rd_en), 1);
    checkOutput("early_addr", 32'(o_addr), 32'h05);
    idleCycles(3);
    checkOutput("early_err_cnt", err_cnt, 1);
    checkOutput("early_wr_cnt", wr_cnt, 0);

    $display("[TB] timeout after W12");
    clearCounts();
    applyStimulus("W12");
    idleCycles(10);
    checkOutput("to_no_early_err", err_cnt, 0);
    idleCycles(50);
    checkOutput("to_err_cnt", err_cnt, 1);
    applyStimulus("W0001");
    sendByte(8'h0D);
    checkOutput("to_wr_en", 32'(o_wr_en), 1);
    checkOutput("to_addr", 32'(o_addr), 32'h00);
    checkOutput("to_data", 32'(o_wr_data), 32'h01);
    idleCycles(3);
    checkOutput("to_wr_cnt", wr_cnt, 1);
    checkOutput("to_err_cnt_final", err_cnt, 1);

    $display("[TB] reset mid-command W12 / reset / 34<CR>");
    clearCounts();
    applyStimulus("W12");
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("mid_rst_wr_en", 32'(o_wr_en), 0);
    checkOutput("mid_rst_rd_en", 32'(o_rd_en), 0);
    checkOutput("mid_rst_err", 32'(o_err), 0);
    checkOutput("mid_rst_addr", 32'(o_addr), 0);
    checkOutput("mid_rst_wr_data", 32'(o_wr_data), 0);
    sendByte(8'h33);
    checkOutput("mid_rst_3_err", 32'(o_err), 1);
    sendByte(8'h34);
    sendByte(8'h0D);
    idleCycles(3);
    checkOutput("mid_rst_wr_cnt", wr_cnt, 0);
    checkOutput("mid_rst_err_cnt", err_cnt, 1);
    checkOutput("strobe_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
